// File: rtl/relocador_enderecos.sv
// Logical-to-physical branch target relocation with a per-process base/limit table.
// Bounds checking is compiled in by defining RELOC_LIMIT_CHECK_EN.
module relocador_enderecos #(
    parameter int ADDR_W    = 11,
    parameter int NUM_PROC  = 8,
    parameter int TAM_BLOCO = 200,
    localparam int PROC_W   = $clog2(NUM_PROC)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [PROC_W-1:0] req_proc,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              rsp_valid,
    output logic [ADDR_W-1:0] rsp_addr,
    output logic              rsp_fault,
    input  logic              cfg_we,
    input  logic [PROC_W-1:0] cfg_proc,
    input  logic [ADDR_W-1:0] cfg_base,
    input  logic [ADDR_W-1:0] cfg_limit,
    output logic              busy
);

    // state   | meaning
    // ST_INIT | walking the table, loading default base/limit, one entry per cycle
    // ST_RUN  | translating requests, accepting cfg writes
    typedef enum logic {ST_INIT, ST_RUN} state_t;

    localparam logic [ADDR_W-1:0] TAM_LIM = ADDR_W'(TAM_BLOCO);

    state_t            state, state_nx;
    logic [PROC_W-1:0] cnt;
    logic [ADDR_W-1:0] init_base;
    logic [ADDR_W-1:0] base_tab [NUM_PROC];
    logic              accept;
    logic [ADDR_W-1:0] sel_base;
    logic [ADDR_W-1:0] sum_addr;
    logic [ADDR_W-1:0] rsp_addr_nx;
    logic              rsp_fault_nx;

    always_ff @(posedge clock) begin
        if (!reset) state <= ST_INIT;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (state == ST_INIT && cnt == PROC_W'(NUM_PROC - 1))
            state_nx = ST_RUN;
    end

    always_comb begin
        busy      = (state == ST_INIT);
        req_ready = (state == ST_RUN);
    end

    always_ff @(posedge clock) begin
        if (!reset)               cnt <= '0;
        else if (state == ST_INIT) cnt <= cnt + 1'b1;
    end

    assign init_base = ADDR_W'(32'(cnt) * 32'(TAM_BLOCO));

    // The table itself needs no reset: INIT rewrites every entry before RUN.
    always_ff @(posedge clock) begin
        if (reset) begin
            if (state == ST_INIT)  base_tab[cnt]      <= init_base;
            else if (cfg_we)       base_tab[cfg_proc] <= cfg_base;
        end
    end

    assign accept   = req_valid && req_ready;
    assign sel_base = base_tab[req_proc];
    assign sum_addr = req_addr + sel_base;

`ifdef RELOC_LIMIT_CHECK_EN
    logic [ADDR_W-1:0] limit_tab [NUM_PROC];

    always_ff @(posedge clock) begin
        if (reset) begin
            if (state == ST_INIT)  limit_tab[cnt]      <= TAM_LIM;
            else if (cfg_we)       limit_tab[cfg_proc] <= cfg_limit;
        end
    end

    always_comb begin
        rsp_addr_nx  = sum_addr;
        rsp_fault_nx = 1'b0;
        if (req_addr >= limit_tab[req_proc]) begin
            rsp_addr_nx  = sel_base;
            rsp_fault_nx = 1'b1;
        end
    end
`else
    logic unused_cfg_limit;
    assign unused_cfg_limit = ^{cfg_limit, TAM_LIM};

    always_comb begin
        rsp_addr_nx  = sum_addr;
        rsp_fault_nx = 1'b0;
    end
`endif

    always_ff @(posedge clock) begin
        if (!reset) begin
            rsp_valid <= 1'b0;
            rsp_addr  <= '0;
            rsp_fault <= 1'b0;
        end else begin
            rsp_valid <= accept;
            if (accept) begin
                rsp_addr  <= rsp_addr_nx;
                rsp_fault <= rsp_fault_nx;
            end
        end
    end

endmodule

// File: tb/tb_relocador_enderecos.sv
// Scoreboard bench for relocador_enderecos at default parameters; expectations
// follow RELOC_LIMIT_CHECK_EN the same way the design does.
module tb_relocador_enderecos;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [2:0]  req_proc = '0;
    logic [10:0] req_addr = '0;
    logic        rsp_valid;
    logic [10:0] rsp_addr;
    logic        rsp_fault;
    logic        cfg_we = 1'b0;
    logic [2:0]  cfg_proc = '0;
    logic [10:0] cfg_base = '0;
    logic [10:0] cfg_limit = '0;
    logic        busy;

    relocador_enderecos dut (
        .clock     (clock),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_proc  (req_proc),
        .req_addr  (req_addr),
        .rsp_valid (rsp_valid),
        .rsp_addr  (rsp_addr),
        .rsp_fault (rsp_fault),
        .cfg_we    (cfg_we),
        .cfg_proc  (cfg_proc),
        .cfg_base  (cfg_base),
        .cfg_limit (cfg_limit),
        .busy      (busy)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [10:0] addr;
        logic        fault;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   base_m [8];
    int   lim_m  [8];
    bit   run_m = 1'b0;
    int   init_left = 8;
    bit   pend = 1'b0;
    bit   known = 1'b0;
    int   n;

    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input int p, input int a);
        exp_t e;
        e.addr  = 11'((a + base_m[p]) % 2048);
        e.fault = 1'b0;
`ifdef RELOC_LIMIT_CHECK_EN
        if (a >= lim_m[p]) begin
            e.addr  = 11'(base_m[p]);
            e.fault = 1'b1;
        end
`endif
        return e;
    endfunction

    // Observe outputs at the falling edge, then drive the inputs for the next rising edge.
    task automatic tick(input bit v, input int p, input int a,
                        input bit w, input int cp, input int cb, input int cl,
                        input bit rn, input bit ue, input int ea, input bit ef);
        exp_t e;
        @(negedge clock);
        if (known) begin
            chk("busy", int'(busy), run_m ? 0 : 1);
            chk("req_ready", int'(req_ready), run_m ? 1 : 0);
            chk("rsp_valid", int'(rsp_valid), int'(pend));
            if (pend && sb.size() > 0) begin
                e = sb.pop_front();
                if (rsp_valid) begin
                    chk("rsp_addr", int'(rsp_addr), int'(e.addr));
                    chk("rsp_fault", int'(rsp_fault), int'(e.fault));
                end
            end
        end
        req_valid = v;
        req_proc  = 3'(p);
        req_addr  = 11'(a);
        cfg_we    = w;
        cfg_proc  = 3'(cp);
        cfg_base  = 11'(cb);
        cfg_limit = 11'(cl);
        reset     = rn;
        if (!rn) begin
            run_m     = 1'b0;
            init_left = 8;
            pend      = 1'b0;
            known     = 1'b1;
            for (int i = 0; i < 8; i++) begin
                base_m[i] = (i * 200) % 2048;
                lim_m[i]  = 200;
            end
        end else if (!run_m) begin
            pend = 1'b0;
            init_left--;
            if (init_left == 0) run_m = 1'b1;
        end else begin
            pend = v;
            if (v) begin
                if (ue) begin
                    e.addr  = 11'(ea);
                    e.fault = ef;
                end else begin
                    e = model(p, a);
                end
                sb.push_back(e);
            end
            if (w) begin
                base_m[cp] = cb;
                lim_m[cp]  = cl;
            end
        end
    endtask

    task automatic idle(input bit rn);
        tick(0, 0, 0, 0, 0, 0, 0, rn, 0, 0, 0);
    endtask

    task automatic req_e(input int p, input int a, input int ea, input bit ef);
        tick(1, p, a, 0, 0, 0, 0, 1, 1, ea, ef);
    endtask

    task automatic cfg(input int cp, input int cb, input int cl);
        tick(0, 0, 0, 1, cp, cb, cl, 1, 0, 0, 0);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) idle(0);
        chk("rst_rsp_valid", int'(rsp_valid), 0);
        chk("rst_rsp_addr", int'(rsp_addr), 0);
        chk("rst_rsp_fault", int'(rsp_fault), 0);
        chk("rst_busy", int'(busy), 1);
        chk("rst_req_ready", int'(req_ready), 0);

        idle(1);
        n = 0;
        while (busy && n < 40) begin
            n++;
            idle(1);
        end
        chk("init_cycles", n, 8);
        chk("ready_after_init", int'(req_ready), 1);

        req_e(3, 10, 610, 0);
        req_e(7, 199, 1599, 0);
`ifdef RELOC_LIMIT_CHECK_EN
        req_e(7, 200, 1400, 1);
`else
        req_e(7, 200, 1600, 0);
`endif
        idle(1);

        cfg(2, 2000, 2047);
        req_e(2, 100, 52, 0);

        // Request and cfg write to the same entry: request must see the old base.
        tick(1, 1, 5, 1, 1, 500, 200, 1, 1, 205, 0);
        req_e(1, 5, 505, 0);

        for (int i = 0; i < 30; i++) begin
            tick(1, $urandom_range(0, 7), $urandom_range(0, 2047),
                 ($urandom_range(0, 3) == 0), $urandom_range(0, 7),
                 $urandom_range(0, 2047), $urandom_range(0, 2047), 1, 0, 0, 0);
        end

        // Reset mid-stream while requests keep coming; cfg writes during INIT must be dropped.
        tick(1, 4, 7, 0, 0, 0, 0, 1, 0, 0, 0);
        tick(1, 5, 9, 0, 0, 0, 0, 0, 0, 0, 0);
        tick(1, 2, 3, 1, 2, 999, 5, 1, 0, 0, 0);
        chk("midrst_rsp_valid", int'(rsp_valid), 0);
        chk("midrst_busy", int'(busy), 1);
        repeat (5) tick(1, 2, 3, 1, 2, 999, 5, 1, 0, 0, 0);
        n = 0;
        while (busy && n < 40) begin
            n++;
            idle(1);
        end
        chk("reinit_done", int'(busy), 0);

        req_e(2, 0, 400, 0);
`ifdef RELOC_LIMIT_CHECK_EN
        req_e(2, 250, 400, 1);
`else
        req_e(2, 250, 650, 0);
`endif
        req_e(1, 5, 205, 0);
        repeat (3) idle(1);
        chk("sb_empty", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
